// File: rtl/mmul_parallel_engine_seq_if.sv
// Purpose : bundle of the job-trigger, sink-stream, out_r observation and
//           kernel-control signals around the mmul_parallel job sequencer.
// Ports   : master modport - controller/kernel side (drives requests and
//           status, observes sequencer outputs).
//           slave modport  - the sequencer (observes requests and status,
//           drives kernel start/clear and job status).
interface mmul_parallel_engine_seq_if #(
    parameter int unsigned NB_IN = 32,
    parameter int unsigned CNT_W = 16
) ();
    logic             trigger_i;
    logic             clear_i;
    logic [CNT_W-1:0] len_i;
    logic [NB_IN-1:0] in_valid_i;
    logic             out_valid_i;
    logic             out_ready_i;
    logic             k_done_i;
    logic             k_idle_i;
    logic             k_ready_i;
    logic             k_start_o;
    logic             k_clear_o;
    logic             busy_o;
    logic             done_o;
    logic             err_timeout_o;
    logic [CNT_W-1:0] cnt_out_o;

    modport master (
        output trigger_i, clear_i, len_i, in_valid_i, out_valid_i, out_ready_i,
               k_done_i, k_idle_i, k_ready_i,
        input  k_start_o, k_clear_o, busy_o, done_o, err_timeout_o, cnt_out_o
    );

    modport slave (
        input  trigger_i, clear_i, len_i, in_valid_i, out_valid_i, out_ready_i,
               k_done_i, k_idle_i, k_ready_i,
        output k_start_o, k_clear_o, busy_o, done_o, err_timeout_o, cnt_out_o
    );
endinterface

// File: rtl/mmul_parallel_engine_seq.sv
// Purpose : job sequencer in front of the mmul_parallel kernel. On a trigger
//           it clears the kernel, waits for every sink stream and kernel
//           ready, issues a one-cycle start, counts out_r beats up to the
//           programmed length, waits for kernel done/idle and reports
//           completion. A watchdog aborts jobs that stop making progress.
// Ports   : clk_i  - clock
//           rst_i  - synchronous active-high reset
//           bus    - slave side of mmul_parallel_engine_seq_if (trigger,
//                    clear, len, stream valids, out_r handshake, kernel
//                    status in; k_start/k_clear, busy, done, sticky
//                    timeout error and beat count out)
module mmul_parallel_engine_seq #(
    parameter int unsigned NB_IN     = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    mmul_parallel_engine_seq_if.slave     bus
);
    typedef enum logic [2:0] {
        IDLE, CLEAR, WAIT_IN, START, RUN, DRAIN, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     len_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_inc;
    logic [TIMEOUT_W-1:0] wd_q;
    logic                 err_q;
    logic                 abort_q;
    logic [NB_IN-1:0]     in_valid;
    logic                 beat;
    logic                 wd_active;
    logic                 timeout;

    assign in_valid = bus.in_valid_i;
    assign beat     = bus.out_valid_i & bus.out_ready_i;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        wd_active = (state_q == WAIT_IN) || (state_q == RUN) || (state_q == DRAIN);
        timeout   = wd_active && (wd_q == '1);
        state_d   = state_q;
        unique case (state_q)
            IDLE:    if (bus.trigger_i) state_d = (bus.len_i == '0) ? DONE : CLEAR;
            CLEAR:   state_d = WAIT_IN;
            WAIT_IN: if ((&in_valid) && bus.k_ready_i) state_d = START;
            START:   state_d = RUN;
            RUN:     if (beat && (cnt_inc == len_q)) state_d = DRAIN;
            DRAIN:   if (bus.k_done_i || bus.k_idle_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Aborts skip the CLEAR state; the kernel clear is issued from abort_q.
        if (timeout || bus.clear_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= bus.clear_i | timeout;
            if (bus.clear_i) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end else begin
                if (state_q == IDLE && bus.trigger_i) begin
                    len_q <= bus.len_i;
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end
                if (state_q == RUN && beat) cnt_q <= cnt_inc;
            end
            // Timeout forces a state change, so the watchdog can never wrap.
            if (!wd_active || bus.clear_i || (state_d != state_q) ||
                (state_q == RUN && beat))
                wd_q <= '0;
            else
                wd_q <= wd_q + TIMEOUT_W'(1);
        end
    end

    assign bus.k_clear_o     = (state_q == CLEAR) || abort_q;
    assign bus.k_start_o     = (state_q == START);
    assign bus.done_o        = (state_q == DONE);
    assign bus.busy_o        = (state_q != IDLE) && (state_q != DONE);
    assign bus.err_timeout_o = err_q;
    assign bus.cnt_out_o     = cnt_q;
endmodule
